icmp_echo_responder: RTL and testbench

//  Parametrised ICMP echo responder. It sits between the IP receive/transmit layers and serves any MAC/IP pair.
//  It buffers one inbound echo request in an inferred payload RAM and verifies its checksum.
//  It then emits the echo reply: type 0, with the checksum recomputed.

---
 rtl/icmp_echo_responder.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_icmp_echo_responder.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icmp_echo_responder.sv
// icmp_echo_responder
//   Buffers one inbound ICMP echo request, verifies its checksum and emits
//   the echo reply (type 0, checksum recomputed) towards the IP transmit layer.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     icmp_rx_req                1-cycle pulse, message bytes start next cycle
//     icmp_rx_data               received byte stream, one byte per cycle
//     icmp_rev_error             receive error, any cycle during reception
//     upper_layer_data_length    ICMP length L, valid with icmp_rx_req
//     ip_tx_ack                  IP layer accepts icmp_tx_req
//     icmp_data_req              IP layer requests the reply bytes
//     mac_send_end               MAC finished transmitting the frame
//     icmp_tx_req/icmp_tx_ready  reply pending / reply data ready
//     icmp_tx_data/icmp_tx_end   reply byte stream / last-byte marker
//     busy                       state is not IDLE
//     stat_rx_ok/stat_csum_err/stat_drop  saturating statistics counters
module icmp_echo_responder #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned TIMEOUT = 65535,
  parameter int unsigned STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icmp_rx_req,
  input  logic [7:0]        icmp_rx_data,
  input  logic              icmp_rev_error,
  input  logic [15:0]       upper_layer_data_length,
  input  logic              ip_tx_ack,
  input  logic              icmp_data_req,
  input  logic              mac_send_end,
  output logic              icmp_tx_req,
  output logic              icmp_tx_ready,
  output logic [7:0]        icmp_tx_data,
  output logic              icmp_tx_end,
  output logic              busy,
  output logic [STAT_W-1:0] stat_rx_ok,
  output logic [STAT_W-1:0] stat_csum_err,
  output logic [STAT_W-1:0] stat_drop
);

  localparam int unsigned MAX_LEN = 8 + 2**ADDR_W;
  localparam int unsigned TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_DISCARD, S_CHECK, S_REQ, S_WAIT_DATA, S_SEND, S_WAIT_END
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [31:0]       rx_sum_q, rx_sum_d;
  logic [31:0]       rep_sum_q, rep_sum_d;
  logic [7:0]        code_q, code_d;
  logic [15:0]       id_q, id_d;
  logic [15:0]       seq_q, seq_d;
  logic [15:0]       csum_q, csum_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_end_q, tx_end_d;
  logic              mac_end_q, mac_end_d;
  logic [STAT_W-1:0] stat_ok_q, stat_ok_d;
  logic [STAT_W-1:0] stat_cerr_q, stat_cerr_d;
  logic [STAT_W-1:0] stat_drop_q, stat_drop_d;

  logic [1:0]        drop_inc;
  logic              ok_inc;
  logic              cerr_inc;
  logic [31:0]       byte_w;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_rd_q;
  logic [7:0]        ram [0:(2**ADDR_W)-1];

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] v,
                                                input logic [1:0]        inc);
    logic [STAT_W:0] s;
    s = {1'b0, v} + (STAT_W+1)'(inc);
    return s[STAT_W] ? '1 : s[STAT_W-1:0];
  endfunction

  function automatic logic [31:0] fold(input logic [31:0] s);
    return {16'd0, s[15:0]} + {16'd0, s[31:16]};
  endfunction

  // Byte k writes RAM[k-8] in RECV; in SEND the same offset prefetches the
  // payload byte one cycle ahead of the output register.
  assign ram_addr = ADDR_W'(cnt_q - 16'd8);

  // Even byte index is the high half of a big-endian word; an odd-length
  // tail therefore lands in the high half, i.e. padded with 0x00.
  assign byte_w = cnt_q[0] ? {24'd0, icmp_rx_data} : {16'd0, icmp_rx_data, 8'd0};

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= icmp_rx_data;
    ram_rd_q <= ram[ram_addr];
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    rx_sum_d  = rx_sum_q;
    rep_sum_d = rep_sum_q;
    code_d    = code_q;
    id_d      = id_q;
    seq_d     = seq_q;
    csum_d    = csum_q;
    tx_data_d = '0;
    tx_end_d  = 1'b0;
    mac_end_d = mac_send_end;
    ram_we    = 1'b0;
    drop_inc  = '0;
    ok_inc    = 1'b0;
    cerr_inc  = 1'b0;

    if (icmp_rx_req && state_q != S_IDLE) drop_inc = drop_inc + 2'd1;

    case (state_q)
      S_IDLE: begin
        if (icmp_rx_req) begin
          len_d     = upper_layer_data_length;
          cnt_d     = '0;
          rx_sum_d  = '0;
          rep_sum_d = '0;
          if (32'(upper_layer_data_length) >= 32'd8 &&
              32'(upper_layer_data_length) <= MAX_LEN) begin
            state_d = S_RECV;
          end else begin
            state_d  = S_DISCARD;
            drop_inc = drop_inc + 2'd1;
          end
        end
      end

      S_RECV: begin
        rx_sum_d = rx_sum_q + byte_w;
        // Reply sum skips type and checksum bytes; word0 becomes {0x00, code}.
        if (cnt_q >= 16'd4)      rep_sum_d = rep_sum_q + byte_w;
        else if (cnt_q == 16'd1) rep_sum_d = rep_sum_q + {24'd0, icmp_rx_data};
        case (cnt_q)
          16'd1:   code_d      = icmp_rx_data;
          16'd4:   id_d[15:8]  = icmp_rx_data;
          16'd5:   id_d[7:0]   = icmp_rx_data;
          16'd6:   seq_d[15:8] = icmp_rx_data;
          16'd7:   seq_d[7:0]  = icmp_rx_data;
          default: ;
        endcase
        ram_we = (cnt_q >= 16'd8);
        cnt_d  = cnt_q + 16'd1;
        if (icmp_rev_error) begin
          drop_inc = drop_inc + 2'd1;
          state_d  = (cnt_q == len_q - 16'd1) ? S_IDLE : S_DISCARD;
        end else if (cnt_q == 16'd0 && icmp_rx_data != 8'h08) begin
          state_d = S_DISCARD;
        end else if (cnt_q == len_q - 16'd1) begin
          state_d = S_CHECK;
          cnt_d   = '0;
        end
      end

      S_DISCARD: begin
        if ((17'(cnt_q) + 17'd1) >= 17'(len_q)) state_d = S_IDLE;
        else                                      cnt_d   = cnt_q + 16'd1;
      end

      S_CHECK: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q <= 16'd1) begin
          rx_sum_d  = fold(rx_sum_q);
          rep_sum_d = fold(rep_sum_q);
        end
        if (cnt_q == 16'd3) begin
          if (rx_sum_q[15:0] == 16'hFFFF) begin
            ok_inc  = 1'b1;
            csum_d  = ~rep_sum_q[15:0];
            state_d = S_REQ;
          end else begin
            cerr_inc = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end

      S_REQ: begin
        if (ip_tx_ack) begin
          state_d = S_WAIT_DATA;
          tmo_d   = '0;
        end
      end

      S_WAIT_DATA: begin
        if (icmp_data_req) begin
          state_d = S_SEND;
          cnt_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          drop_inc = drop_inc + 2'd1;
          state_d  = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_SEND: begin
        // cnt_q = j+1 registers byte j; cnt_q = 0 is the RAM prefetch slot.
        cnt_d = cnt_q + 16'd1;
        case (cnt_q)
          16'd0:   tx_data_d = 8'h00;
          16'd1:   tx_data_d = 8'h00;
          16'd2:   tx_data_d = code_q;
          16'd3:   tx_data_d = csum_q[15:8];
          16'd4:   tx_data_d = csum_q[7:0];
          16'd5:   tx_data_d = id_q[15:8];
          16'd6:   tx_data_d = id_q[7:0];
          16'd7:   tx_data_d = seq_q[15:8];
          16'd8:   tx_data_d = seq_q[7:0];
          default: tx_data_d = ram_rd_q;
        endcase
        if (cnt_q == len_q) begin
          tx_end_d = 1'b1;
          state_d  = S_WAIT_END;
        end
      end

      S_WAIT_END: begin
        if (mac_end_q) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    stat_ok_d   = sat_add(stat_ok_q,   {1'b0, ok_inc});
    stat_cerr_d = sat_add(stat_cerr_q, {1'b0, cerr_inc});
    stat_drop_d = sat_add(stat_drop_q, drop_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      rx_sum_q    <= '0;
      rep_sum_q   <= '0;
      code_q      <= '0;
      id_q        <= '0;
      seq_q       <= '0;
      csum_q      <= '0;
      tx_data_q   <= '0;
      tx_end_q    <= 1'b0;
      mac_end_q   <= 1'b0;
      stat_ok_q   <= '0;
      stat_cerr_q <= '0;
      stat_drop_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      rx_sum_q    <= rx_sum_d;
      rep_sum_q   <= rep_sum_d;
      code_q      <= code_d;
      id_q        <= id_d;
      seq_q       <= seq_d;
      csum_q      <= csum_d;
      tx_data_q   <= tx_data_d;
      tx_end_q    <= tx_end_d;
      mac_end_q   <= mac_end_d;
      stat_ok_q   <= stat_ok_d;
      stat_cerr_q <= stat_cerr_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign icmp_tx_req   = (state_q == S_REQ);
  assign icmp_tx_ready = (state_q == S_WAIT_DATA);
  assign icmp_tx_data  = tx_data_q;
  assign icmp_tx_end   = tx_end_q;
  assign busy          = (state_q != S_IDLE);
  assign stat_rx_ok    = stat_ok_q;
  assign stat_csum_err = stat_cerr_q;
  assign stat_drop     = stat_drop_q;

endmodule

// File: tb/tb_icmp_echo_responder.sv
// tb_icmp_echo_responder
//   Self-checking bench for icmp_echo_responder with a small payload RAM and
//   a short reply timeout. Messages and expected replies are built from byte
//   queues with a plain one's-complement checksum function.
`timescale 1ns/1ps
module tb_icmp_echo_responder;

  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned STAT_W  = 16;
  localparam int          MAX_L   = 8 + (1 << ADDR_W);

  typedef logic [7:0] bq_t [$];

  logic              clk;
  logic              rst_n;
  logic              icmp_rx_req;
  logic [7:0]        icmp_rx_data;
  logic              icmp_rev_error;
  logic [15:0]       upper_layer_data_length;
  logic              ip_tx_ack;
  logic              icmp_data_req;
  logic              mac_send_end;
  logic              icmp_tx_req;
  logic              icmp_tx_ready;
  logic [7:0]        icmp_tx_data;
  logic              icmp_tx_end;
  logic              busy;
  logic [STAT_W-1:0] stat_rx_ok;
  logic [STAT_W-1:0] stat_csum_err;
  logic [STAT_W-1:0] stat_drop;

  int n_checks = 0;
  int n_errors = 0;
  int exp_ok   = 0;
  int exp_cerr = 0;
  int exp_drop = 0;

  icmp_echo_responder #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT),
    .STAT_W (STAT_W)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .icmp_rx_req            (icmp_rx_req),
    .icmp_rx_data           (icmp_rx_data),
    .icmp_rev_error         (icmp_rev_error),
    .upper_layer_data_length(upper_layer_data_length),
    .ip_tx_ack              (ip_tx_ack),
    .icmp_data_req          (icmp_data_req),
    .mac_send_end           (mac_send_end),
    .icmp_tx_req            (icmp_tx_req),
    .icmp_tx_ready          (icmp_tx_ready),
    .icmp_tx_data           (icmp_tx_data),
    .icmp_tx_end            (icmp_tx_end),
    .busy                   (busy),
    .stat_rx_ok             (stat_rx_ok),
    .stat_csum_err          (stat_csum_err),
    .stat_drop              (stat_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ones_sum(input bq_t q);
    logic [31:0] s;
    logic [7:0]  lo;
    s = 0;
    for (int i = 0; i < q.size(); i += 2) begin
      lo = (i + 1 < q.size()) ? q[i+1] : 8'h00;
      s  = s + {16'h0, q[i], lo};
    end
    while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return s[15:0];
  endfunction

  function automatic bq_t make_req(input logic [7:0] typ, input logic [7:0] code,
                                   input logic [15:0] id, input logic [15:0] seq,
                                   input bq_t pl);
    bq_t m;
    logic [15:0] c;
    m.push_back(typ);      m.push_back(code);
    m.push_back(8'h00);    m.push_back(8'h00);
    m.push_back(id[15:8]); m.push_back(id[7:0]);
    m.push_back(seq[15:8]); m.push_back(seq[7:0]);
    foreach (pl[i]) m.push_back(pl[i]);
    c = ~ones_sum(m);
    m[2] = c[15:8];
    m[3] = c[7:0];
    return m;
  endfunction

  function automatic bq_t make_reply(input bq_t m);
    bq_t r;
    logic [15:0] c;
    r = m;
    r[0] = 8'h00;
    r[2] = 8'h00;
    r[3] = 8'h00;
    c = ~ones_sum(r);
    r[2] = c[15:8];
    r[3] = c[7:0];
    return r;
  endfunction

  function automatic bq_t ramp(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(i));
    return q;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  task automatic check_stats(input string tag);
    chk({tag, "_rx_ok"},   32'(stat_rx_ok),    32'(exp_ok));
    chk({tag, "_csum_err"}, 32'(stat_csum_err), 32'(exp_cerr));
    chk({tag, "_drop"},    32'(stat_drop),     32'(exp_drop));
  endtask

  task automatic send_msg(input bq_t m, input int err_at);
    @(negedge clk);
    icmp_rx_req = 1'b1;
    upper_layer_data_length = 16'(m.size());
    @(negedge clk);
    icmp_rx_req = 1'b0;
    for (int k = 0; k < m.size(); k++) begin
      icmp_rx_data   = m[k];
      icmp_rev_error = (k == err_at);
      @(negedge clk);
    end
    icmp_rx_data   = 8'h00;
    icmp_rev_error = 1'b0;
  endtask

  task automatic wait_tx_req(output int w);
    w = 0;
    while (icmp_tx_req !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("tx_req_latency", 32'(w), 32'd4);
  endtask

  task automatic do_echo(input bq_t m, input int dly, input int inject_at, input int rst_at);
    bq_t exp;
    bq_t got;
    int  w;
    exp = make_reply(m);
    send_msg(m, -1);
    exp_ok++;
    wait_tx_req(w);
    if (w >= 20) return;
    ip_tx_ack = 1'b1;
    @(negedge clk);
    ip_tx_ack = 1'b0;
    chk("tx_req_clear", 32'(icmp_tx_req), 32'd0);
    chk("tx_ready", 32'(icmp_tx_ready), 32'd1);
    repeat (dly) @(negedge clk);
    icmp_data_req = 1'b1;
    @(negedge clk);
    icmp_data_req = 1'b0;
    @(negedge clk);
    chk("pre_byte_zero", 32'(icmp_tx_data), 32'd0);
    for (int j = 0; j < exp.size(); j++) begin
      @(negedge clk);
      icmp_rx_req = 1'b0;
      if (j == rst_at) begin
        rst_n = 1'b0;
        exp_ok = 0; exp_cerr = 0; exp_drop = 0;
        @(negedge clk);
        chk("rst_tx_req", 32'(icmp_tx_req), 32'd0);
        chk("rst_tx_ready", 32'(icmp_tx_ready), 32'd0);
        chk("rst_tx_data", 32'(icmp_tx_data), 32'd0);
        chk("rst_tx_end", 32'(icmp_tx_end), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        check_stats("rst");
        rst_n = 1'b1;
        return;
      end
      got.push_back(icmp_tx_data);
      chk($sformatf("reply_byte%0d", j), 32'(icmp_tx_data), 32'(exp[j]));
      chk($sformatf("tx_end_byte%0d", j), 32'(icmp_tx_end), 32'(j == exp.size() - 1));
      if (j == inject_at) begin
        icmp_rx_req = 1'b1;
        upper_layer_data_length = 16'd40;
        exp_drop++;
      end
    end
    icmp_rx_req = 1'b0;
    chk("reply_csum_verify", 32'(ones_sum(got)), 32'h0000FFFF);
    @(negedge clk);
    chk("post_tx_end", 32'(icmp_tx_end), 32'd0);
    chk("post_tx_data", 32'(icmp_tx_data), 32'd0);
    chk("wait_end_busy", 32'(busy), 32'd1);
    mac_send_end = 1'b1;
    @(negedge clk);
    mac_send_end = 1'b0;
    w = 0;
    while (busy && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("wait_end_exit", 32'(w), 32'd1);
    check_stats("echo");
  endtask

  task automatic do_bad(input bq_t m);
    send_msg(m, -1);
    exp_cerr++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bad_check_busy", 32'(busy), 32'd1);
      chk("bad_no_tx_req", 32'(icmp_tx_req), 32'd0);
    end
    @(negedge clk);
    chk("bad_idle", 32'(busy), 32'd0);
    chk("bad_no_tx_req_end", 32'(icmp_tx_req), 32'd0);
    check_stats("bad");
  endtask

  task automatic do_discard(input bq_t m, input int err_at, input bit counts);
    send_msg(m, err_at);
    if (counts) exp_drop++;
    chk("discard_idle", 32'(busy), 32'd0);
    chk("discard_no_tx_req", 32'(icmp_tx_req), 32'd0);
    check_stats("discard");
  endtask

  task automatic do_timeout(input bq_t m);
    int w;
    int n;
    send_msg(m, -1);
    exp_ok++;
    wait_tx_req(w);
    if (w >= 20) return;
    ip_tx_ack = 1'b1;
    @(negedge clk);
    ip_tx_ack = 1'b0;
    n = 0;
    while (icmp_tx_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    exp_drop++;
    chk("timeout_ready_cycles", 32'(n), 32'(TIMEOUT));
    chk("timeout_idle", 32'(busy), 32'd0);
    check_stats("timeout");
  endtask

  initial begin
    bq_t m;
    int  l;
    int  k;
    rst_n = 1'b0;
    icmp_rx_req = 1'b0;
    icmp_rx_data = 8'h00;
    icmp_rev_error = 1'b0;
    upper_layer_data_length = 16'h0;
    ip_tx_ack = 1'b0;
    icmp_data_req = 1'b0;
    mac_send_end = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx_req", 32'(icmp_tx_req), 32'd0);
    chk("reset_tx_ready", 32'(icmp_tx_ready), 32'd0);
    chk("reset_tx_data", 32'(icmp_tx_data), 32'd0);
    chk("reset_tx_end", 32'(icmp_tx_end), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    check_stats("reset");
    rst_n = 1'b1;

    // 40-byte echo and odd-length 41-byte echo
    m = make_req(8'h08, 8'h00, 16'h1234, 16'h0007, ramp(32));
    do_echo(m, 3, -1, -1);
    m = make_req(8'h08, 8'h00, 16'h1234, 16'h0008, ramp(33));
    do_echo(m, 0, -1, -1);

    // corrupted payload bit
    m = make_req(8'h08, 8'h00, 16'h1234, 16'h0009, ramp(32));
    m[20] = m[20] ^ 8'h04;
    do_bad(m);

    // receive error, wrong type, out-of-range lengths
    m = make_req(8'h08, 8'h00, 16'hBEEF, 16'h0001, ramp(32));
    do_discard(m, 12, 1'b1);
    m = make_req(8'h00, 8'h00, 16'hBEEF, 16'h0002, ramp(32));
    do_discard(m, -1, 1'b0);
    do_discard(rand_bytes(6), -1, 1'b1);
    do_discard(rand_bytes(MAX_L + 1), -1, 1'b1);

    // minimum and maximum accepted lengths
    m = make_req(8'h08, 8'h00, 16'h0101, 16'h0202, rand_bytes(0));
    do_echo(m, 1, -1, -1);
    m = make_req(8'h08, 8'h00, 16'h0303, 16'h0404, rand_bytes(MAX_L - 8));
    do_echo(m, 2, -1, -1);

    // data_req never arrives
    m = make_req(8'h08, 8'h00, 16'h5555, 16'h0010, ramp(16));
    do_timeout(m);

    // overlapping request during SEND, reset mid-SEND, then a clean request
    m = make_req(8'h08, 8'h00, 16'hA5A5, 16'h0011, rand_bytes(32));
    do_echo(m, 2, 5, -1);
    m = make_req(8'h08, 8'h00, 16'hA5A5, 16'h0012, rand_bytes(32));
    do_echo(m, 1, -1, 10);
    m = make_req(8'h08, 8'h00, 16'hC0DE, 16'h0013, rand_bytes(24));
    do_echo(m, 4, -1, -1);

    // randomized traffic
    for (int it = 0; it < 10; it++) begin
      l = $urandom_range(8, MAX_L);
      m = make_req(8'h08, 8'($urandom_range(0, 255)), 16'($urandom()), 16'($urandom()),
                   rand_bytes(l - 8));
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(1, l - 1);
        m[k] = m[k] ^ 8'(1 << $urandom_range(0, 7));
        do_bad(m);
      end else begin
        do_echo(m, $urandom_range(0, 12), -1, -1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
